dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory (`datamem`).
- Port 0 is the CPU load/store path. Port 1 is the program loader / debug port, which preloads or inspects memory.
- It serialises requests, drives the memory's `Ina`/`Inb`/`enable`/`readwrite` pins, and waits a fixed read latency before capturing `dataOut`.
- It returns a one-cycle acknowledge to the granted requester and keeps per-port transfer counters.

Parameters:
- AW, 32, address width (memory uses the low 16 bits; all AW bits pass through unchanged).
- DW, 32, data width.
- RD_LAT, 1, cycles from the end of the ISSUE cycle to a valid `mem_rdata`; legal range 1..15.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  port 0 request; held high with fields stable until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 completion pulse, one cycle.
- req1, we1, addr1, wdata1, ack1  as port 0, for port 1.
- rdata  out  DW  read data; valid only while ack0 or ack1 is high.
- busy  out  1  high in any state other than IDLE.
- gnt  out  1  index of the port currently or last granted.
- mem_addr  out  AW  to datamem `Ina`.
- mem_wdata  out  DW  to datamem `Inb`.
- mem_en  out  1  to datamem `enable`.
- mem_rw  out  1  to datamem `readwrite` (1 = write).
- mem_rdata  in  DW  from datamem `dataOut`.
- xfer_cnt0  out  16  completed port 0 transfers, saturating at 0xFFFF.
- xfer_cnt1  out  16  completed port 1 transfers, saturating at 0xFFFF.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - ack0 = ack1 = 0, mem_en = 0, mem_rw = 0.
  - mem_addr = 0, mem_wdata = 0, rdata = 0, busy = 0.
  - gnt = 1 (last_grant = 1), so port 0 wins the first round-robin tie.
  - xfer_cnt0 = xfer_cnt1 = 0.
- Output timing: all outputs come from registers or from decode of the registered state; there are no combinational paths from input to output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select the winning port g:
    - Only one request: that port.
    - Both requests, PRIO_MODE=0: the port other than last_grant.
    - Both requests, PRIO_MODE=1: port 0.
  - Latch we_g, addr_g and wdata_g into mem_rw, mem_addr and mem_wdata. Set gnt = g. Go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_rw, mem_addr and mem_wdata hold their latched values.
  - A write lands in memory at the closing edge; next state is RESP.
  - A read goes to WAIT with wcnt = RD_LAT-1.
- WAIT:
  - mem_en = 0; mem_addr is held.
  - If wcnt == 0, capture mem_rdata into rdata and go to RESP; otherwise decrement wcnt. WAIT therefore lasts RD_LAT cycles.
- RESP (one cycle):
  - ack_g = 1. rdata holds the captured read data, or 0 for a write.
  - Set last_grant = g and increment xfer_cnt_g unless it is already 0xFFFF.
  - Next state is IDLE. At exit, ack drops and rdata clears to 0.
- Latency from the first IDLE cycle with req high to ack high:
  - Write: 2 cycles.
  - Read: 2 + RD_LAT cycles.
- Throughput:
  - Minimum write cycle is 3 clocks (IDLE, ISSUE, RESP).
  - Minimum read cycle is 3 + RD_LAT clocks.
- Handshake:
  - A requester drops req, or presents a new request, on the edge at which it samples ack.
  - The arbiter re-arbitrates in the next IDLE.
- Request dropped before ack:
  - The latched transaction still completes and the ack pulse is still issued.
  - Field changes after the IDLE sample are ignored.
- Simultaneous events:
  - A request arriving while busy is held off; it is never lost as long as req stays high.
  - Round-robin alternates strictly under continuous contention, so there is no starvation.
- Reset mid-operation:
  - Immediate return to IDLE; outputs take their reset values.
  - An in-flight read is abandoned and no ack is issued.
  - A write in ISSUE is suppressed because mem_en drops asynchronously.
  - The counters clear.

Test Plan:
- Reset, then port 0 write: req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF.
  - mem_en=1, mem_rw=1 for exactly 1 cycle.
  - ack0 2 cycles after the request; xfer_cnt0=1.
  - A following read of address 5 returns rdata=0xDEADBEEF with ack0 at 3 cycles for RD_LAT=1.
- RD_LAT=3, port 1 read of address 2 holding 0x00000011: ack1 5 cycles after the request, rdata=0x00000011, busy high for 5 cycles.
- Round-robin contention: both ports keep req high for 4 transactions each, starting right after reset.
  - Grant order is 0,1,0,1,…
  - Final xfer_cnt0 = xfer_cnt1 = 4.
- PRIO_MODE=1 with the same stimulus: port 0 wins every tie; port 1 is granted only once req0 is low.
- Assert rst during the WAIT of a read: ack0 never pulses, busy=0 immediately, counters=0, and mem_en stays low.
- Drive 0x10000 port 0 writes: xfer_cnt0 saturates at 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Serialises port 0 (CPU) and port 1 (loader/debug) accesses and keeps per-port transfer counters.
//
// state | meaning
// IDLE  | no transfer in flight; arbitrate and latch the winner's fields
// ISSUE | mem_en high for one cycle; a write lands at the closing edge
// WAIT  | read latency countdown; capture mem_rdata when wcnt reaches 0
// RESP  | one-cycle ack to the granted port; bump its counter
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          gnt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_en,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   xfer_cnt0,
  output logic [15:0]   xfer_cnt1
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] WCNT_INIT = 4'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        gnt_q;
  logic        sel;
  logic [3:0]  wcnt_q;
  logic [15:0] cnt0_q, cnt1_q;

  // gnt_q doubles as last_grant: it only changes when a new winner is chosen
  always_comb begin
    state_d = state_q;
    sel     = gnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ISSUE;
          if (req0 && req1)
            sel = (PRIO_MODE != 0) ? 1'b0 : ~gnt_q;
          else
            sel = req1;
        end
      end
      ISSUE:   state_d = mem_rw ? RESP : WAIT;
      WAIT:    if (wcnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b1;
      wcnt_q    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
      rdata     <= '0;
      cnt0_q    <= 16'd0;
      cnt1_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (state_d == ISSUE) begin
            gnt_q     <= sel;
            mem_rw    <= sel ? we1 : we0;
            mem_addr  <= sel ? addr1 : addr0;
            mem_wdata <= sel ? wdata1 : wdata0;
          end
        end
        ISSUE: wcnt_q <= WCNT_INIT;
        WAIT: begin
          if (wcnt_q == 4'd0)
            rdata <= mem_rdata;
          else
            wcnt_q <= wcnt_q - 4'd1;
        end
        RESP: begin
          rdata <= '0;
          if (!gnt_q && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
          if (gnt_q && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so reset drops mem_en immediately
  assign ack0      = (state_q == RESP) && !gnt_q;
  assign ack1      = (state_q == RESP) && gnt_q;
  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign gnt       = gnt_q;
  assign xfer_cnt0 = cnt0_q;
  assign xfer_cnt1 = cnt1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 is round-robin with RD_LAT=1, instance 1 is fixed priority with RD_LAT=3.
// A behavioural memory sits behind each instance; expectations come from a shadow memory and arbitration rules.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst[2];
  logic        req0[2], we0[2], req1[2], we1[2];
  logic [31:0] addr0[2], wdata0[2], addr1[2], wdata1[2];
  logic        ack0[2], ack1[2], busy[2], gnt[2], mem_en[2], mem_rw[2];
  logic [31:0] rdata[2], mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic [15:0] xfer_cnt0[2], xfer_cnt1[2];

  logic [31:0] mem[2][256];
  logic [31:0] pipe[2][3];

  logic [31:0] ref_mem[2][16];
  bit          ref_valid[2][16];
  int          ref_cnt[2][2];
  int          n_chk, n_pass;

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .PRIO_MODE(0)) u0 (
    .clk(clk), .rst(rst[0]),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .ack1(ack1[0]),
    .rdata(rdata[0]), .busy(busy[0]), .gnt(gnt[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_en(mem_en[0]), .mem_rw(mem_rw[0]),
    .mem_rdata(mem_rdata[0]), .xfer_cnt0(xfer_cnt0[0]), .xfer_cnt1(xfer_cnt1[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .PRIO_MODE(1)) u1 (
    .clk(clk), .rst(rst[1]),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .ack1(ack1[1]),
    .rdata(rdata[1]), .busy(busy[1]), .gnt(gnt[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_en(mem_en[1]), .mem_rw(mem_rw[1]),
    .mem_rdata(mem_rdata[1]), .xfer_cnt0(xfer_cnt0[1]), .xfer_cnt1(xfer_cnt1[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: write at the enabling edge; read data appears RD_LAT cycles after it
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] && mem_rw[d]) mem[d][mem_addr[d][7:0]] <= mem_wdata[d];
      pipe[d][0] <= (mem_en[d] && !mem_rw[d]) ? mem[d][mem_addr[d][7:0]] : 32'hBAADF00D;
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic drive_port(input int d, input int p, input bit w, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      we0[d] = w; addr0[d] = a; wdata0[d] = wd; req0[d] = 1'b1;
    end else begin
      we1[d] = w; addr1[d] = a; wdata1[d] = wd; req1[d] = 1'b1;
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1; req0[d] = 1'b0; req1[d] = 1'b0;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    ref_cnt[d][0] = 0; ref_cnt[d][1] = 0;
  endtask

  // One single-port transfer from IDLE; also advances the reference model
  task automatic xfer(input int d, input int p, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat, output int nen, output int nwr,
                      output int nbusy, output logic [3:0] post);
    drive_port(d, p, w, a, wd);
    lat = -1; nen = 0; nwr = 0; nbusy = 0; rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_en[d]) nen++;
      if (mem_en[d] && mem_rw[d]) nwr++;
      if (busy[d]) nbusy++;
      if ((p == 0) ? ack0[d] : ack1[d]) begin
        lat = i; rd = rdata[d];
        break;
      end
    end
    req0[d] = 1'b0; req1[d] = 1'b0;
    @(posedge clk); #1;
    post = {ack0[d], ack1[d], busy[d], |rdata[d]};
    if (w) begin
      ref_mem[d][a[3:0]] = wd; ref_valid[d][a[3:0]] = 1'b1;
    end
    if (ref_cnt[d][p] < 65535) ref_cnt[d][p]++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({ack0[d], ack1[d], busy[d], gnt[d], mem_en[d], mem_rw[d]} !== 6'b000100)
        $display("FAIL reset_ctrl d=%0d got %b want 000100", d,
                 {ack0[d], ack1[d], busy[d], gnt[d], mem_en[d], mem_rw[d]});
      else n_pass++;
      n_chk++;
      if ({mem_addr[d], mem_wdata[d], rdata[d]} !== 96'd0)
        $display("FAIL reset_data d=%0d addr=%h wdata=%h rdata=%h want 0", d, mem_addr[d], mem_wdata[d], rdata[d]);
      else n_pass++;
      n_chk++;
      if ({xfer_cnt0[d], xfer_cnt1[d]} !== 32'd0)
        $display("FAIL reset_cnt d=%0d got %h/%h want 0", d, xfer_cnt0[d], xfer_cnt1[d]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat, nen, nwr, nb; logic [3:0] post;
    xfer(0, 0, 1'b1, 32'd5, 32'hDEADBEEF, rd, lat, nen, nwr, nb, post);
    n_chk++;
    if (lat !== 2) $display("FAIL wr_latency got %0d want 2", lat); else n_pass++;
    n_chk++;
    if (nen !== 1 || nwr !== 1) $display("FAIL wr_en_pulse got en=%0d wr=%0d want 1/1", nen, nwr); else n_pass++;
    n_chk++;
    if (xfer_cnt0[0] !== 16'(ref_cnt[0][0])) $display("FAIL wr_cnt0 got %0d want %0d", xfer_cnt0[0], ref_cnt[0][0]);
    else n_pass++;
    n_chk++;
    if (post !== 4'b0) $display("FAIL wr_after got %b want 0000", post); else n_pass++;
    xfer(0, 0, 1'b0, 32'd5, 32'd0, rd, lat, nen, nwr, nb, post);
    n_chk++;
    if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else n_pass++;
    n_chk++;
    if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rd); else n_pass++;
    n_chk++;
    if (nen !== 1 || nwr !== 0) $display("FAIL rd_en_pulse got en=%0d wr=%0d want 1/0", nen, nwr); else n_pass++;
  endtask

  task automatic test_lat3_read();
    logic [31:0] rd; int lat, nen, nwr, nb; logic [3:0] post;
    xfer(1, 1, 1'b1, 32'd2, 32'h00000011, rd, lat, nen, nwr, nb, post);
    xfer(1, 1, 1'b0, 32'd2, 32'd0, rd, lat, nen, nwr, nb, post);
    n_chk++;
    if (lat !== 5) $display("FAIL lat3_latency got %0d want 5", lat); else n_pass++;
    n_chk++;
    if (rd !== 32'h11) $display("FAIL lat3_data got %h want 00000011", rd); else n_pass++;
    n_chk++;
    if (nb !== 5) $display("FAIL lat3_busy got %0d want 5", nb); else n_pass++;
    n_chk++;
    if (post !== 4'b0) $display("FAIL lat3_after got %b want 0000", post); else n_pass++;
    n_chk++;
    if (xfer_cnt1[1] !== 16'(ref_cnt[1][1])) $display("FAIL lat3_cnt1 got %0d want %0d", xfer_cnt1[1], ref_cnt[1][1]);
    else n_pass++;
  endtask

  task automatic test_random(input int d);
    logic [31:0] rd, a, wd, exp; int p, lat, nen, nwr, nb, exp_lat; bit w; logic [3:0] post;
    for (int i = 0; i < 24; i++) begin
      p = int'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      if (!w && !ref_valid[d][a[3:0]]) w = 1'b1;
      wd = $urandom;
      exp = w ? 32'd0 : ref_mem[d][a[3:0]];
      exp_lat = w ? 2 : 2 + lat_of(d);
      xfer(d, p, w, a, wd, rd, lat, nen, nwr, nb, post);
      n_chk++;
      if (lat !== exp_lat || rd !== exp)
        $display("FAIL rand d=%0d op=%0d got lat=%0d data=%h want lat=%0d data=%h", d, i, lat, rd, exp_lat, exp);
      else n_pass++;
      n_chk++;
      if (gnt[d] !== 1'(p)) $display("FAIL rand_gnt d=%0d op=%0d got %b want %0d", d, i, gnt[d], p); else n_pass++;
    end
    n_chk++;
    if (xfer_cnt0[d] !== 16'(ref_cnt[d][0]) || xfer_cnt1[d] !== 16'(ref_cnt[d][1]))
      $display("FAIL rand_cnt d=%0d got %0d/%0d want %0d/%0d", d, xfer_cnt0[d], xfer_cnt1[d], ref_cnt[d][0], ref_cnt[d][1]);
    else n_pass++;
  endtask

  // Both ports hold req continuously; port 0 uses addresses 0..7, port 1 uses 8..15
  task automatic test_contention(input int d);
    int rem[2]; int q_exp[$]; int q_got[$]; int last, g, got;
    bit wcur[2]; logic [31:0] acur[2], dcur[2];
    do_reset(d);
    last = 1; rem[0] = 4; rem[1] = 4;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) g = (d == 1) ? 0 : 1 - last;
      else g = (rem[0] > 0) ? 0 : 1;
      q_exp.push_back(g); last = g; rem[g]--;
    end
    rem[0] = 4; rem[1] = 4;
    for (int p = 0; p < 2; p++) begin
      acur[p] = 32'(p * 8 + int'($urandom_range(0, 7)));
      wcur[p] = 1'($urandom_range(0, 1)) || !ref_valid[d][acur[p][3:0]];
      dcur[p] = $urandom;
      drive_port(d, p, wcur[p], acur[p], dcur[p]);
    end
    for (int c = 0; c < 200 && (rem[0] > 0 || rem[1] > 0); c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? ack0[d] : ack1[d]) begin
          q_got.push_back(p);
          if (!wcur[p]) begin
            n_chk++;
            if (rdata[d] !== ref_mem[d][acur[p][3:0]])
              $display("FAIL cont_rdata d=%0d port=%0d got %h want %h", d, p, rdata[d], ref_mem[d][acur[p][3:0]]);
            else n_pass++;
          end else begin
            ref_mem[d][acur[p][3:0]] = dcur[p]; ref_valid[d][acur[p][3:0]] = 1'b1;
          end
          ref_cnt[d][p]++;
          rem[p]--;
          if (rem[p] > 0) begin
            acur[p] = 32'(p * 8 + int'($urandom_range(0, 7)));
            wcur[p] = 1'($urandom_range(0, 1)) || !ref_valid[d][acur[p][3:0]];
            dcur[p] = $urandom;
            drive_port(d, p, wcur[p], acur[p], dcur[p]);
          end else if (p == 0) req0[d] = 1'b0;
          else req1[d] = 1'b0;
        end
      end
    end
    req0[d] = 1'b0; req1[d] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < q_exp.size(); k++) begin
      got = (k < q_got.size()) ? q_got[k] : -1;
      n_chk++;
      if (got !== q_exp[k]) $display("FAIL cont_order d=%0d slot=%0d got %0d want %0d", d, k, got, q_exp[k]);
      else n_pass++;
    end
    n_chk++;
    if (xfer_cnt0[d] !== 16'd4 || xfer_cnt1[d] !== 16'd4)
      $display("FAIL cont_cnt d=%0d got %0d/%0d want 4/4", d, xfer_cnt0[d], xfer_cnt1[d]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    drive_port(1, 0, 1'b0, 32'd2, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy[1] !== 1'b1 || mem_en[1] !== 1'b0) $display("FAIL mid_pre got busy=%b en=%b want 1/0", busy[1], mem_en[1]);
    else n_pass++;
    rst[1] = 1'b1;
    #1;
    n_chk++;
    if ({busy[1], mem_en[1], ack0[1], ack1[1], gnt[1]} !== 5'b00001 || rdata[1] !== 32'd0)
      $display("FAIL mid_rst got ctrl=%b rdata=%h want 00001/0", {busy[1], mem_en[1], ack0[1], ack1[1], gnt[1]}, rdata[1]);
    else n_pass++;
    n_chk++;
    if (xfer_cnt0[1] !== 16'd0 || xfer_cnt1[1] !== 16'd0)
      $display("FAIL mid_cnt got %0d/%0d want 0/0", xfer_cnt0[1], xfer_cnt1[1]);
    else n_pass++;
    req0[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    ref_cnt[1][0] = 0; ref_cnt[1][1] = 0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack0[1] || ack1[1] || mem_en[1] || busy[1]) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL mid_quiet got %0d active cycles want 0", bad); else n_pass++;
  endtask

  // Counter preset near the top stands in for 0xFFFC completed writes
  task automatic test_saturation();
    logic [31:0] rd; int lat, nen, nwr, nb; logic [3:0] post;
    u0.cnt0_q = 16'hFFFC;
    ref_cnt[0][0] = 32'hFFFC;
    for (int i = 0; i < 5; i++) begin
      xfer(0, 0, 1'b1, 32'(i), $urandom, rd, lat, nen, nwr, nb, post);
      n_chk++;
      if (xfer_cnt0[0] !== 16'(ref_cnt[0][0]))
        $display("FAIL sat_cnt0 step=%0d got %h want %h", i, xfer_cnt0[0], 16'(ref_cnt[0][0]));
      else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req0[d] = 1'b0; req1[d] = 1'b0; we0[d] = 1'b0; we1[d] = 1'b0;
      addr0[d] = '0; addr1[d] = '0; wdata0[d] = '0; wdata1[d] = '0;
      ref_cnt[d][0] = 0; ref_cnt[d][1] = 0;
      for (int a = 0; a < 16; a++) begin
        ref_mem[d][a] = '0; ref_valid[d][a] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst[0] = 1'b0; rst[1] = 1'b0;
    test_write_read();
    test_lat3_read();
    test_random(0);
    test_random(1);
    test_contention(0);
    test_contention(1);
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
